// File: rtl/cpu_pkg.sv
// Shared CPU types used by the load/store unit: data width, access sizes, LSU states.
package cpu_pkg;

    localparam int WORD = 32;

    typedef enum logic [1:0] {
        MEM_B = 2'd0,
        MEM_H = 2'd1,
        MEM_W = 2'd2
    } mem_size_e;

    typedef enum logic {
        LSU_IDLE  = 1'b0,
        LSU_SPLIT = 1'b1
    } lsu_state_e;

    // Size encoding 3 is illegal and behaves as a word access.
    function automatic mem_size_e norm_size(input logic [1:0] size);
        return (size == 2'd3) ? MEM_W : mem_size_e'(size);
    endfunction

    // An access crosses into the next word when its bytes do not fit in lanes offset..3.
    function automatic logic is_crossing(input mem_size_e size, input logic [1:0] offset);
        return ((size == MEM_H) && (offset == 2'd3)) ||
               ((size == MEM_W) && (offset != 2'd0));
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane logic for the LSU: store merge into an existing word and load
// extract/combine/extend. The access is viewed through a two-word window
// {upper word, lower word}; 'upper' selects which half of the window this
// dmem cycle touches.
module lsu_align
    import cpu_pkg::*;
(
    input  mem_size_e        size,
    input  logic             is_unsigned,
    input  logic [1:0]       offset,
    input  logic             upper,
    input  logic [WORD-1:0]  wdata,
    input  logic [WORD-1:0]  cur_word,
    input  logic [WORD-1:0]  low_word,
    output logic [WORD-1:0]  merged,
    output logic [WORD-1:0]  load_data
);

    logic [3:0]        size_mask;
    logic [7:0]        be_win;
    logic [2*WORD-1:0] wd_win;
    logic [2*WORD-1:0] rd_win;
    logic [3:0]        be;
    logic [WORD-1:0]   wd;
    logic [WORD-1:0]   raw;

    // Lane selection, store merge and load extension for the current dmem cycle.
    always_comb begin
        case (size)
            MEM_B:   size_mask = 4'b0001;
            MEM_H:   size_mask = 4'b0011;
            default: size_mask = 4'b1111;
        endcase

        be_win = {4'b0000, size_mask} << offset;
        wd_win = {{WORD{1'b0}}, wdata} << {offset, 3'b000};
        be     = upper ? be_win[7:4] : be_win[3:0];
        wd     = upper ? wd_win[2*WORD-1:WORD] : wd_win[WORD-1:0];

        merged = cur_word;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                merged[8*i +: 8] = wd[8*i +: 8];
            end
        end

        // Second cycle of a split load: captured word supplies the low bytes.
        rd_win = upper ? {cur_word, low_word} : {{WORD{1'b0}}, cur_word};
        raw    = rd_win[{offset, 3'b000} +: WORD];

        case (size)
            MEM_B:   load_data = is_unsigned ? {24'd0, raw[7:0]}  : {{24{raw[7]}},  raw[7:0]};
            MEM_H:   load_data = is_unsigned ? {16'd0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
            default: load_data = raw;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit in front of a word-indexed dmem. Aligned accesses
// complete in one cycle; word-crossing accesses take a second SPLIT cycle on
// the next word index (wrapping at the dmem depth) with req_ready held low.
module mem_lsu
    import cpu_pkg::*;
#(
    parameter int DMEM_POWER = 18
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [1:0]       req_size,
    input  logic             req_unsigned,
    input  logic [WORD-1:0]  req_addr,
    input  logic [WORD-1:0]  req_wdata,
    output logic             resp_valid,
    output logic [WORD-1:0]  resp_rdata,
    output logic             dmem_we,
    output logic [WORD-1:0]  dmem_addr,
    output logic [WORD-1:0]  dmem_wdata,
    input  logic [WORD-1:0]  dmem_rdata
);

    lsu_state_e            state, state_next;

    // Request fields latched for the SPLIT cycle.
    mem_size_e             size_p1;
    logic                  uns_p1;
    logic                  we_p1;
    logic [1:0]            off_p1;
    logic [WORD-1:0]       wdata_p1;
    logic [DMEM_POWER-1:0] idx_p1;
    logic [WORD-1:0]       cap_word;

    mem_size_e             req_sz;
    logic [1:0]            req_off;
    logic [DMEM_POWER-1:0] req_idx;
    logic                  crossing;
    logic                  accept;

    mem_size_e             a_size;
    logic                  a_uns;
    logic [1:0]            a_off;
    logic                  a_upper;
    logic [WORD-1:0]       a_wdata;
    logic [DMEM_POWER-1:0] idx;
    logic [WORD-1:0]       merged;
    logic [WORD-1:0]       load_data;
    logic                  resp_fire;
    logic                  resp_load;

    // Byte address bits above the dmem depth are ignored.
    logic                  unused_addr;
    assign unused_addr = ^req_addr[WORD-1:DMEM_POWER+2];

    assign req_sz   = norm_size(req_size);
    assign req_off  = req_addr[1:0];
    assign req_idx  = req_addr[DMEM_POWER+1:2];
    assign crossing = is_crossing(req_sz, req_off);
    // Holding rst_n in the accept term keeps dmem quiet while reset is asserted.
    assign accept   = req_valid && (state == LSU_IDLE) && rst_n;

    // Next state, dmem drive and lane-logic operand selection.
    always_comb begin
        state_next = state;
        req_ready  = (state == LSU_IDLE);
        dmem_we    = 1'b0;
        a_size     = req_sz;
        a_uns      = req_unsigned;
        a_off      = req_off;
        a_upper    = 1'b0;
        a_wdata    = req_wdata;
        idx        = req_idx;
        resp_fire  = 1'b0;
        resp_load  = 1'b0;

        case (state)
            LSU_IDLE: begin
                dmem_we   = accept && req_we;
                resp_fire = accept && !crossing;
                resp_load = accept && !crossing && !req_we;
                if (accept && crossing) begin
                    state_next = LSU_SPLIT;
                end
            end
            LSU_SPLIT: begin
                a_size     = size_p1;
                a_uns      = uns_p1;
                a_off      = off_p1;
                a_upper    = 1'b1;
                a_wdata    = wdata_p1;
                idx        = idx_p1;
                dmem_we    = we_p1;
                resp_fire  = 1'b1;
                resp_load  = !we_p1;
                state_next = LSU_IDLE;
            end
            default: state_next = LSU_IDLE;
        endcase

        dmem_addr  = {{(WORD-DMEM_POWER){1'b0}}, idx};
        dmem_wdata = merged;
    end

    lsu_align u_align (
        .size        (a_size),
        .is_unsigned (a_uns),
        .offset      (a_off),
        .upper       (a_upper),
        .wdata       (a_wdata),
        .cur_word    (dmem_rdata),
        .low_word    (cap_word),
        .merged      (merged),
        .load_data   (load_data)
    );

    // FSM state register; reset aborts any split in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LSU_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Capture request and first-word data when a crossing access is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            size_p1  <= MEM_B;
            uns_p1   <= 1'b0;
            we_p1    <= 1'b0;
            off_p1   <= 2'd0;
            wdata_p1 <= '0;
            idx_p1   <= '0;
            cap_word <= '0;
        end else if (accept && crossing) begin
            size_p1  <= req_sz;
            uns_p1   <= req_unsigned;
            we_p1    <= req_we;
            off_p1   <= req_off;
            wdata_p1 <= req_wdata;
            idx_p1   <= req_idx + 1'b1;
            cap_word <= dmem_rdata;
        end
    end

    // Response register: one-cycle pulse, load data extended, zero for stores.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid <= 1'b0;
            resp_rdata <= '0;
        end else begin
            resp_valid <= resp_fire;
            resp_rdata <= resp_load ? load_data : '0;
        end
    end

endmodule
